// File: rtl/spi_memory_pkg.sv
// rtl/spi_memory_pkg.sv - shared types and constants for the SPI byte memory
//
// Contents:
//   state_t          frame-level FSM states
//   ADDR_W, DATA_W   default address / data widths
//   RW_READ/RW_WRITE encoding of the R/W bit that follows the address
package spi_memory_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      WRITE,
      READ_LOAD,
      READ,
      DONE
   } state_t;

endpackage

// File: rtl/spi_input_conditioner.sv
// rtl/spi_input_conditioner.sv - pin synchronizer with registered edge strobes
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   pin          raw asynchronous input
//   level        synchronized level (SYNC_STAGES flops after the pin)
//   rise, fall   single-clk strobes, SYNC_STAGES+1 clk after the pin edge
// RST_VAL is the idle level of the pin, so leaving reset never fakes an edge.
module spi_input_conditioner #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   assign level = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q[0] <= pin;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= level;
         rise   <= level & ~prev_q;
         fall   <= ~level & prev_q;
      end
   end

endmodule

// File: rtl/spi_memory.sv
// rtl/spi_memory.sv - SPI-slave (mode 0) accessible byte memory
//
// Ports:
//   clk, rst_n   system clock (>= 8x SCLK), asynchronous active-low reset
//   sclk_pin     SPI clock, mode 0, asynchronous
//   cs_pin       chip select, active-low, asynchronous
//   miso_pin     serial data to master, MSB first
//   mosi_pin     serial data from master, MSB first
//   leds         low nibble of the last byte written or read
// Frame: A[ADDR_W-1:0], R/W (1 = read), D[DATA_W-1:0].
// Build option SPI_MEMORY_MISO_TRISTATE_EN: miso_pin floats (1'bz) when not
// reading instead of driving 0.
module spi_memory
   import spi_memory_pkg::*;
#(
   parameter int ADDR_W      = spi_memory_pkg::ADDR_W,
   parameter int DATA_W      = spi_memory_pkg::DATA_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_pin,
   input  logic       cs_pin,
   output logic       miso_pin,
   input  logic       mosi_pin,
   output logic [3:0] leds
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W + 1);

   // Last bit index of each phase: the header carries ADDR_W+1 bits
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic sclk_level, sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise, mosi_fall;

   spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
      .clk(clk), .rst_n(rst_n), .pin(sclk_pin),
      .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk(clk), .rst_n(rst_n), .pin(cs_pin),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_input_conditioner #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst_n(rst_n), .pin(mosi_pin),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   // CS is handled by level, SCLK by strobes, MOSI by level only
   logic unused_strobes;
   assign unused_strobes = &{1'b0, sclk_level, cs_rise, mosi_rise, mosi_fall};

   state_t              state, state_next;
   logic [CNT_W-1:0]    bit_cnt;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_sr;
   logic [DATA_W-1:0]   out_sr;
   logic                first_fall;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   wr_byte;
   logic                reading;

   // Byte as it stands once the current MOSI bit is included
   assign wr_byte = {data_sr[DATA_W-2:0], mosi_level};

   always_comb begin
      state_next = state;
      if (cs_level) begin
         // Deselect overrides everything, including a same-cycle SCLK edge
         state_next = IDLE;
      end else begin
         case (state)
            IDLE:      if (cs_fall) state_next = GET_ADDR;
            GET_ADDR:  if (sclk_rise && bit_cnt == ADDR_LAST)
                          state_next = (mosi_level == RW_READ) ? READ_LOAD : WRITE;
            READ_LOAD: state_next = READ;
            READ:      if (sclk_rise && bit_cnt == DATA_LAST) state_next = DONE;
            WRITE:     if (sclk_rise && bit_cnt == DATA_LAST) state_next = DONE;
            DONE:      state_next = DONE;
            default:   state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         addr_q     <= '0;
         data_sr    <= '0;
         out_sr     <= '0;
         first_fall <= 1'b0;
         leds       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         state <= state_next;

         // Every phase starts counting from zero
         if (state_next != state) begin
            bit_cnt <= '0;
         end else if (sclk_rise && (state == GET_ADDR || state == WRITE || state == READ)) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
         end

         case (state)
            GET_ADDR: begin
               // The final header bit is R/W, so it never enters the address
               if (sclk_rise && bit_cnt != ADDR_LAST) begin
                  addr_q <= {addr_q[ADDR_W-2:0], mosi_level};
               end
            end
            READ_LOAD: begin
               if (!cs_level) begin
                  out_sr     <= mem[addr_q];
                  leds       <= mem[addr_q][3:0];
                  first_fall <= 1'b1;
               end
            end
            READ: begin
               // D7 is already on the line; the first fall only presents it
               if (sclk_fall) begin
                  if (first_fall) begin
                     first_fall <= 1'b0;
                  end else begin
                     out_sr <= out_sr << 1;
                  end
               end
            end
            WRITE: begin
               if (sclk_rise) begin
                  data_sr <= wr_byte;
                  if (bit_cnt == DATA_LAST && !cs_level) begin
                     mem[addr_q] <= wr_byte;
                     leds        <= wr_byte[3:0];
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign reading = (state == READ_LOAD) || (state == READ);

`ifdef SPI_MEMORY_MISO_TRISTATE_EN
   assign miso_pin = reading ? out_sr[DATA_W-1] : 1'bz;
`else
   assign miso_pin = reading & out_sr[DATA_W-1];
`endif

endmodule

// File: tb/tb_spi_memory.sv
// tb/tb_spi_memory.sv - directed self-checking bench for spi_memory
module tb_spi_memory;

   localparam int HALF = 80;   // half SCLK period in ns (8 clk)

`ifdef SPI_MEMORY_MISO_TRISTATE_EN
   localparam logic MISO_IDLE = 1'bz;
`else
   localparam logic MISO_IDLE = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       sclk_pin;
   logic       cs_pin;
   logic       miso_pin;
   logic       mosi_pin;
   logic [3:0] leds;

   int n_cmp;
   int n_bad;

   spi_memory dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sclk_pin (sclk_pin),
      .cs_pin   (cs_pin),
      .miso_pin (miso_pin),
      .mosi_pin (mosi_pin),
      .leds     (leds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic spi_begin();
      cs_pin = 1'b0;
      #(HALF);
   endtask

   task automatic spi_end();
      #(HALF);
      cs_pin   = 1'b1;
      mosi_pin = 1'b0;
      #(HALF * 2);
   endtask

   // Shift nbits of tx MSB first; rx captures MISO just before each rise
   task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         mosi_pin = tx[i];
         #(HALF);
         rx[i]    = miso_pin;
         sclk_pin = 1'b1;
         #(HALF);
         sclk_pin = 1'b0;
      end
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d);
      logic [7:0] rx;
      spi_begin();
      spi_byte({a, 1'b0}, 8, rx);
      spi_byte(d, 8, rx);
      spi_end();
   endtask

   task automatic do_read(input logic [6:0] a, output logic [7:0] d);
      logic [7:0] rx;
      spi_begin();
      spi_byte({a, 1'b1}, 8, rx);
      spi_byte(8'h00, 8, d);
      spi_end();
   endtask

   task automatic test_reset();
      if (miso_pin !== MISO_IDLE) begin
         $display("FAIL reset_miso: got %b expected %b", miso_pin, MISO_IDLE);
         n_bad++;
      end
      n_cmp++;
      if (leds !== 4'h0) begin
         $display("FAIL reset_leds: got %h expected 0", leds);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_write_read();
      logic [7:0] rd;
      logic [7:0] exp_byte;
      exp_byte = 8'h92;
      do_write(7'h55, 8'h92);
      if (leds !== 4'h2) begin
         $display("FAIL wr_leds: got %h expected 2", leds);
         n_bad++;
      end
      n_cmp++;
      do_read(7'h55, rd);
      for (int i = 7; i >= 0; i--) begin
         if (rd[i] !== exp_byte[i]) begin
            $display("FAIL rd_bit%0d: got %b expected %b", i, rd[i], exp_byte[i]);
            n_bad++;
         end
         n_cmp++;
      end
      if (leds !== 4'h2) begin
         $display("FAIL rd_leds: got %h expected 2", leds);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_reset_midframe();
      logic [7:0] rx;
      spi_begin();
      spi_byte({7'h55, 1'b1}, 4, rx);
      rst_n = 1'b0;
      #20;
      if (miso_pin !== MISO_IDLE) begin
         $display("FAIL midrst_miso: got %b expected %b", miso_pin, MISO_IDLE);
         n_bad++;
      end
      n_cmp++;
      if (leds !== 4'h0) begin
         $display("FAIL midrst_leds: got %h expected 0", leds);
         n_bad++;
      end
      n_cmp++;
      cs_pin   = 1'b1;
      sclk_pin = 1'b0;
      mosi_pin = 1'b0;
      #40;
      rst_n = 1'b1;
      #(HALF * 2);
      do_read(7'h55, rx);
      if (rx !== 8'h00) begin
         $display("FAIL midrst_mem: got %h expected 00", rx);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_abort();
      logic [7:0] rx;
      spi_begin();
      spi_byte({7'h10, 1'b0}, 8, rx);
      spi_byte(8'hFF, 4, rx);
      spi_end();
      if (leds !== 4'h0) begin
         $display("FAIL abort_leds: got %h expected 0", leds);
         n_bad++;
      end
      n_cmp++;
      do_read(7'h10, rx);
      if (rx !== 8'h00) begin
         $display("FAIL abort_mem: got %h expected 00", rx);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_addr_extremes();
      logic [7:0] rx;
      do_write(7'h00, 8'hA5);
      do_write(7'h7F, 8'h3C);
      do_read(7'h00, rx);
      if (rx !== 8'hA5) begin
         $display("FAIL ext_addr00: got %h expected a5", rx);
         n_bad++;
      end
      n_cmp++;
      do_read(7'h7F, rx);
      if (rx !== 8'h3C) begin
         $display("FAIL ext_addr7f: got %h expected 3c", rx);
         n_bad++;
      end
      n_cmp++;
      if (leds !== 4'hC) begin
         $display("FAIL ext_leds: got %h expected c", leds);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_extra_clocks();
      logic [7:0] rx;
      logic [7:0] rd;
      spi_begin();
      spi_byte({7'h7F, 1'b1}, 8, rx);
      spi_byte(8'h00, 8, rd);
      if (rd !== 8'h3C) begin
         $display("FAIL extra_read: got %h expected 3c", rd);
         n_bad++;
      end
      n_cmp++;
      mosi_pin = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #(HALF);
         if (miso_pin !== MISO_IDLE) begin
            $display("FAIL extra_miso%0d: got %b expected %b", k, miso_pin, MISO_IDLE);
            n_bad++;
         end
         n_cmp++;
         sclk_pin = 1'b1;
         #(HALF);
         sclk_pin = 1'b0;
      end
      spi_end();
      if (leds !== 4'hC) begin
         $display("FAIL extra_leds: got %h expected c", leds);
         n_bad++;
      end
      n_cmp++;
      do_read(7'h00, rx);
      if (rx !== 8'hA5) begin
         $display("FAIL extra_next: got %h expected a5", rx);
         n_bad++;
      end
      n_cmp++;
   endtask

   task automatic test_tristate();
      #(HALF);
      if (miso_pin !== MISO_IDLE) begin
         $display("FAIL cs_high_miso: got %b expected %b", miso_pin, MISO_IDLE);
         n_bad++;
      end
      n_cmp++;
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      cs_pin   = 1'b1;
      sclk_pin = 1'b0;
      mosi_pin = 1'b0;
      #40;
      @(negedge clk);
      rst_n = 1'b1;
      #(HALF);

      test_reset();
      test_write_read();
      test_reset_midframe();
      test_abort();
      test_addr_extremes();
      test_extra_clocks();
      test_tristate();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
